// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared widths, instruction field positions and queue entry type
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;
  localparam int RESET_PC = 0;

  // Field positions used by decode; fetch itself passes words through untouched
  localparam int RI_BIT  = 31;
  localparam int RS_MSB  = 30;
  localparam int RS_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int FU_MSB  = 20;
  localparam int FU_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Purpose  : Memory read port and decode handshake of the fetch unit
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DATA_W = fetch_pkg::DATA_W
) ();

  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] ReadData;
  logic              FetchEnable;
  logic              Redirect;
  logic [ADDR_W-1:0] RedirectPC;
  logic              InstrValid;
  logic [DATA_W-1:0] Instr;
  logic [ADDR_W-1:0] InstrPC;
  logic              InstrReady;

  modport master (
    output Address,
    input  ReadData,
    input  FetchEnable,
    input  Redirect,
    input  RedirectPC,
    output InstrValid,
    output Instr,
    output InstrPC,
    input  InstrReady
  );

  modport slave (
    input  Address,
    output ReadData,
    output FetchEnable,
    output Redirect,
    output RedirectPC,
    input  InstrValid,
    input  Instr,
    input  InstrPC,
    output InstrReady
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : 2-entry shifting prefetch FIFO with flush and registered head
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
(
  input  wire logic         Clk,
  input  wire logic         Reset_n,
  input  wire logic         i_push,
  input  wire logic         i_pop,
  input  wire logic         i_flush,
  input  wire fetch_entry_t i_din,
  output fetch_entry_t      o_head,
  output logic [1:0]        o_count
);

  fetch_entry_t r_e0;
  fetch_entry_t r_e1;
  logic [1:0]   r_count;

  // r_e0 is always the head, so the output never depends on a read pointer
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_e0    <= '0;
      r_e1    <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_e0 <= i_din;
          else                 r_e1 <= i_din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_e0    <= r_e1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_e0 <= r_e1;
            r_e1 <= i_din;
          end else begin
            r_e0 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_e0;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : PC owner and push/redirect control in front of the prefetch queue
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int              ADDR_W   = fetch_pkg::ADDR_W,
  parameter int              DATA_W   = fetch_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC)
) (
  input  wire logic           Clk,
  input  wire logic           Reset_n,
  instruction_fetch_if.master bus
);

  import fetch_pkg::*;

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] w_rdata;
  logic [1:0]        w_count;
  logic              w_pop;
  logic              w_push;
  fetch_entry_t      w_din;
  fetch_entry_t      w_head;

  assign w_rdata = bus.ReadData;

  // Redirect suppresses both sides of the handshake for its cycle
  assign w_pop  = (w_count != 2'd0) && bus.InstrReady && !bus.Redirect;
  assign w_push = bus.FetchEnable && !bus.Redirect && ((w_count != 2'd2) || w_pop);

  assign w_din.instr = w_rdata;
  assign w_din.pc    = r_pc;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc <= RESET_PC;
    end else if (bus.Redirect) begin
      r_pc <= bus.RedirectPC;
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  fetch_queue u_queue (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.Redirect),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.Address    = r_pc;
  assign bus.InstrValid = (w_count != 2'd0);
  assign bus.Instr      = w_head.instr;
  assign bus.InstrPC    = w_head.pc;

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: the reader side of the instruction memory. It owns the program counter and drives the memory's 6-bit word address. It captures each returned 32-bit instruction into a 2-entry prefetch queue and hands instructions to decode over a valid/ready handshake. It supports a branch/jump redirect that flushes in-flight instructions, and it sits between the instruction memory and the decode stage.

## Interface
Parameters:
- ADDR_W, 6, word-address width; the PC wraps modulo 2^ADDR_W.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clk, input, 1, single clock; all state updates on the rising edge.
- Reset_n, input, 1, asynchronous active-low reset.
- Address, output, ADDR_W, word address to the instruction memory; equals the PC register.
- ReadData, input, DATA_W, instruction from memory, valid combinationally in the same cycle as Address.
- FetchEnable, input, 1, when low no new fetch is pushed; the queue still drains.
- Redirect, input, 1, one-cycle pulse: flush and restart fetch at RedirectPC.
- RedirectPC, input, ADDR_W, new PC, sampled when Redirect=1.
- InstrValid, output, 1, queue head holds a valid instruction.
- Instr, output, DATA_W, queue head instruction.
- InstrPC, output, ADDR_W, address the head instruction was fetched from.
- InstrReady, input, 1, decode accepts the head this cycle.

## Operation
- **State:**
  - PC register.
  - 2-entry queue of {instruction, pc}.
  - count ∈ {0,1,2}.
- **Pop:** InstrValid && InstrReady.
- **Push:** FetchEnable && !Redirect && (count<2 || pop). A push writes {ReadData, PC} to the tail; the PC advances by 1 and wraps from 63 to 0.
- **Simultaneous push and pop:** count unchanged; order is preserved.
- **Redirect** has priority over everything else:
  - count goes to 0 and PC loads RedirectPC.
  - No push and no pop are counted that cycle, even if InstrReady=1.
  - InstrValid is 0 in the following cycle.
- **FetchEnable low:** the PC holds and the queue only drains.
- **Content:** no decoding is performed; instructions are passed through unmodified, including all-zero words.
- **Outputs:** InstrValid = (count!=0). Instr and InstrPC come from head-entry registers, not from ReadData.
- **Reset (asynchronous, any time, including mid-stream):**
  - PC=RESET_PC, count=0, InstrValid=0.
  - Instr=0, InstrPC=0, and all queue storage cleared.
  - Address=RESET_PC.

## Timing
- Fetch-to-valid latency is 1 cycle: a word pushed in cycle N is visible at the head in cycle N+1 if the queue was empty.
- Sustained throughput is 1 instruction/cycle while InstrReady=1 and FetchEnable=1.
- After Reset_n deasserts with FetchEnable=1:
  - Cycle 0: fetches PC 0.
  - Cycle 1: InstrValid=1 with InstrPC=0, and Address=1.
- Backpressure:
  - With InstrReady=0, the queue fills after 2 pushes.
  - Address then holds at the next unfetched PC; the memory is stateless, so this is safe.
- Redirect latency:
  - Redirect asserted in cycle N: Address=RedirectPC in cycle N+1, and that word is pushed in N+1.
  - InstrValid=1 with InstrPC=RedirectPC in cycle N+2.
- Wrap-around: the fetch after PC 63 is PC 0, with no gap and no flag.
- Instr and InstrPC must remain stable while InstrValid=1 and InstrReady=0.

## Structure
- **Shared package (fetch_pkg)** holds:
  - ADDR_W, DATA_W, RESET_PC constants.
  - The instruction field positions used downstream: RI bit 31, rs [30:26], rd [25:21], fu [20:16], RT/IMM [15:0].
  - A typedef for the queue entry {instr, pc}.
- **Sub-module fetch_queue:**
  - 2-entry synchronous FIFO with push, pop, flush, count, and registered head.
  - instruction_fetch holds only the PC and the push/redirect control.

## Test plan
- **Reset and stream:** reset, then FetchEnable=1 and InstrReady=1, with memory holding word k = 32'h1000_0000+k. Expect InstrValid from cycle 1 and InstrPC = 0,1,2,… with Instr matching, one per cycle.
- **Backpressure:** InstrReady=0 for 5 cycles from reset.
  - Expect count=2, head InstrPC=0 held stable, and Address stuck at 2.
  - Release InstrReady: expect PCs 0,1,2,3 delivered with no loss or duplication.
- **Redirect while full:** queue holds PCs 4,5; pulse Redirect with RedirectPC=20 and InstrReady=1.
  - Next cycle: InstrValid=0, Address=20.
  - Cycle after: InstrPC=20, then 21, 22.
- **Wrap:** Redirect to 62. Expect delivered InstrPC sequence 62, 63, 0, 1.
- **FetchEnable gating:** drop FetchEnable while 2 entries are queued and InstrReady=1.
  - Expect exactly 2 more instructions, then InstrValid=0 with Address constant.
  - Raise FetchEnable again: fetch resumes at the held PC.
- **Reset mid-operation:** assert Reset_n=0 asynchronously between edges with count=2. Immediately expect InstrValid=0, Instr=0, and Address=RESET_PC without waiting for a clock edge.
